// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package rf_arb_pkg;

    // Default sizes; the arbiter takes these as parameter defaults.
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int MAX_WAIT = 4;

    // Arbiter states: clearing sweep, normal arbitration, forced host slot.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOST = 2'd2
    } state_t;

endpackage

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the stage-3 writeback
// path and a host/loader port. After reset it clears every register with a
// sweep. While sweeping, and whenever the host has lost too many cycles in a
// row, it stalls the pipeline so the host can be served.
module rf_write_arbiter #(
    parameter int DATA_W   = rf_arb_pkg::DATA_W,
    parameter int ADDR_W   = rf_arb_pkg::ADDR_W,
    parameter int NUM_REGS = rf_arb_pkg::NUM_REGS,
    parameter int MAX_WAIT = rf_arb_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_ws,
    input  logic              wb_we,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_ws,
    output logic [DATA_W-1:0] rf_data,
    output logic              init_done
);
    import rf_arb_pkg::*;

    localparam int                WCNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [WCNT_W-1:0] MAX_WAIT_C = WCNT_W'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [WCNT_W-1:0]   wcnt_inc;
    logic                init_done_q, init_done_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_ws_q, rf_ws_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;

    // The counter only increments in RUN, where it is below MAX_WAIT, so the
    // incremented value always fits.
    assign wcnt_inc = wcnt_q + WCNT_W'(1);

    // Grant selection, next-state and counter updates for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        init_done_d = init_done_q;
        rf_we_d     = 1'b0;
        rf_ws_d     = rf_ws_q;
        rf_data_d   = rf_data_q;
        stall       = 1'b0;
        host_ready  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                stall     = 1'b1;
                rf_we_d   = 1'b1;
                rf_ws_d   = idx_q;
                rf_data_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            ST_RUN: begin
                if (wb_we) begin
                    rf_we_d   = 1'b1;
                    rf_ws_d   = wb_ws;
                    rf_data_d = wb_data;
                    if (host_valid) begin
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc >= MAX_WAIT_C) begin
                            state_d = ST_HOST;
                        end
                    end
                end else if (host_valid) begin
                    host_ready = 1'b1;
                    rf_we_d    = 1'b1;
                    rf_ws_d    = host_addr;
                    rf_data_d  = host_data;
                    wcnt_d     = '0;
                end
            end

            ST_HOST: begin
                if (host_valid) begin
                    // The stall makes the pipeline re-present the writeback.
                    stall      = 1'b1;
                    host_ready = 1'b1;
                    rf_we_d    = 1'b1;
                    rf_ws_d    = host_addr;
                    rf_data_d  = host_data;
                end else if (wb_we) begin
                    // Host withdrew its request: behave as an ordinary RUN cycle.
                    rf_we_d   = 1'b1;
                    rf_ws_d   = wb_ws;
                    rf_data_d = wb_data;
                end
                wcnt_d  = '0;
                state_d = ST_RUN;
            end

            default: state_d = ST_INIT;
        endcase
    end

    // State and registered write-port outputs; reset restarts the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            wcnt_q      <= '0;
            init_done_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_ws_q     <= '0;
            rf_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            init_done_q <= init_done_d;
            rf_we_q     <= rf_we_d;
            rf_ws_q     <= rf_ws_d;
            rf_data_q   <= rf_data_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_ws     = rf_ws_q;
    assign rf_data   = rf_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected write-port activity is queued
// as each cycle's stimulus is driven and compared one clock later.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] wb_data;
    logic [4:0]  wb_ws;
    logic        wb_we;
    logic        host_valid;
    logic [4:0]  host_addr;
    logic [31:0] host_data;
    logic        host_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_ws;
    logic [31:0] rf_data;
    logic        init_done;

    typedef struct packed {
        logic        we;
        logic [4:0]  ws;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  model_ws   = '0;
    logic [31:0] model_data = '0;

    rf_write_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_REGS(32),
        .MAX_WAIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_data   (wb_data),
        .wb_ws     (wb_ws),
        .wb_we     (wb_we),
        .host_valid(host_valid),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_ready(host_ready),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_ws     (rf_ws),
        .rf_data   (rf_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle. Inputs are already driven (posedge+1). Checks the
    // combinational outputs, queues the expected grant, then after the edge
    // pops it and checks the registered write port.
    task automatic step(input string tag, input logic exp_stall, input logic exp_ready,
                        input logic g_we, input logic [4:0] g_ws, input logic [31:0] g_data);
        wr_t e;
        #3;
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        check({tag, ".host_ready"}, 32'(host_ready), 32'(exp_ready));
        exp_q.push_back('{we: g_we, ws: g_ws, data: g_data});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.we) begin
            model_ws   = e.ws;
            model_data = e.data;
        end
        check({tag, ".rf_we"}, 32'(rf_we), 32'(e.we));
        check({tag, ".rf_ws"}, 32'(rf_ws), 32'(model_ws));
        check({tag, ".rf_data"}, rf_data, model_data);
    endtask

    task automatic set_wb(input logic we, input logic [4:0] ws, input logic [31:0] d);
        wb_we   = we;
        wb_ws   = ws;
        wb_data = d;
    endtask

    task automatic set_host(input logic v, input logic [4:0] a, input logic [31:0] d);
        host_valid = v;
        host_addr  = a;
        host_data  = d;
    endtask

    // Full clearing sweep right after reset release.
    task automatic sweep_check();
        set_wb(1'b0, 5'd0, 32'd0);
        set_host(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            step("sweep", 1'b1, 1'b0, 1'b1, 5'(i), 32'd0);
            check("sweep.init_done", 32'(init_done), 32'(i == 31));
        end
    endtask

    initial begin
        int n;
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_host(1'b0, 5'd0, 32'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.rf_we", 32'(rf_we), 32'd0);
        check("rst.rf_ws", 32'(rf_ws), 32'd0);
        check("rst.rf_data", rf_data, 32'd0);
        check("rst.init_done", 32'(init_done), 32'd0);
        check("rst.stall", 32'(stall), 32'd1);
        check("rst.host_ready", 32'(host_ready), 32'd0);
        rst = 1'b1;
        sweep_check();

        // Idle RUN cycle: no grant, no stall.
        step("idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Host write with an idle pipeline.
        set_host(1'b1, 5'd7, 32'hDEADBEEF);
        step("host_idle", 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
        set_host(1'b0, 5'd0, 32'd0);
        step("host_idle.after", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Starvation: 4 writeback grants, 1 host slot, repeating every 5 cycles.
        n = 0;
        set_host(1'b1, 5'd3, 32'h12345678);
        for (int c = 0; c < 10; c++) begin
            set_wb(1'b1, 5'(10 + n), 32'h100 + 32'(n));
            if (c % 5 == 4) begin
                step("starve.host", 1'b1, 1'b1, 1'b1, 5'd3, 32'h12345678);
            end else begin
                step("starve.wb", 1'b0, 1'b0, 1'b1, 5'(10 + n), 32'h100 + 32'(n));
                n++;
            end
        end
        // The writeback stalled by the second host slot is granted now.
        set_host(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'(10 + n), 32'h100 + 32'(n));
        step("starve.regrant", 1'b0, 1'b0, 1'b1, 5'(10 + n), 32'h100 + 32'(n));
        set_wb(1'b0, 5'd0, 32'd0);
        step("starve.idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Same-address collision in the HOST cycle: host value lands first.
        set_wb(1'b1, 5'd5, 32'hA);
        set_host(1'b1, 5'd5, 32'hB);
        for (int c = 0; c < 4; c++) step("coll.wb", 1'b0, 1'b0, 1'b1, 5'd5, 32'hA);
        step("coll.host", 1'b1, 1'b1, 1'b1, 5'd5, 32'hB);
        set_host(1'b0, 5'd0, 32'd0);
        step("coll.wb_after", 1'b0, 1'b0, 1'b1, 5'd5, 32'hA);
        set_wb(1'b0, 5'd0, 32'd0);
        step("coll.idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Protocol violation: host drops valid while in HOST.
        set_wb(1'b1, 5'd8, 32'h44);
        set_host(1'b1, 5'd2, 32'h77);
        for (int c = 0; c < 4; c++) step("viol.wb", 1'b0, 1'b0, 1'b1, 5'd8, 32'h44);
        set_host(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd9, 32'h55);
        step("viol.host_state", 1'b0, 1'b0, 1'b1, 5'd9, 32'h55);
        // Counter was cleared: host must lose exactly 4 more times first.
        set_host(1'b1, 5'd2, 32'h77);
        set_wb(1'b1, 5'd8, 32'h44);
        for (int c = 0; c < 4; c++) step("viol.cnt_clear", 1'b0, 1'b0, 1'b1, 5'd8, 32'h44);
        step("viol.host", 1'b1, 1'b1, 1'b1, 5'd2, 32'h77);
        set_host(1'b0, 5'd0, 32'd0);
        step("viol.regrant", 1'b0, 1'b0, 1'b1, 5'd8, 32'h44);

        // Reset asserted during a HOST cycle with a pending host request.
        set_host(1'b1, 5'd4, 32'hCAFE);
        for (int c = 0; c < 4; c++) step("mid.wb", 1'b0, 1'b0, 1'b1, 5'd8, 32'h44);
        #2;
        check("mid.pre.stall", 32'(stall), 32'd1);
        check("mid.pre.host_ready", 32'(host_ready), 32'd1);
        rst = 1'b0;
        #1;
        model_ws   = '0;
        model_data = '0;
        check("mid.rf_we", 32'(rf_we), 32'd0);
        check("mid.rf_ws", 32'(rf_ws), 32'd0);
        check("mid.rf_data", rf_data, 32'd0);
        check("mid.host_ready", 32'(host_ready), 32'd0);
        check("mid.stall", 32'(stall), 32'd1);
        check("mid.init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1;
        check("mid.hold.rf_we", 32'(rf_we), 32'd0);
        rst = 1'b1;
        sweep_check();
        step("final.idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("scoreboard.empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
